argmax_stream_classifier: RTL and testbench
===========================================

// Module: argmax_stream_classifier
// PURPOSE
//  Final classification stage of the CNN datapath. Consumes one frame of NUM_CLASSES signed
//  class scores over a valid/ready stream and reports the winning class index and its score.
//  Running single-comparator argmax: no per-class register bank, handshake on both sides.
//  Sits between the last FC layer output and the host/result register interface.
// PARAMETERS
//  DATA_W       32  width of signed class score (matches INTERNAL_BITS)
//  NUM_CLASSES  10  scores per frame; legal range 2..256
//  IDX_W        $clog2(NUM_CLASSES)  width of the class index (derived localparam)
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst          in   1       asynchronous, active-high reset
//  clear        in   1       synchronous frame abort; returns to IDLE
//  in_valid     in   1       score on in_data is valid
//  in_ready     out  1       block can accept a score this cycle
//  in_data      in   DATA_W  signed class score, class order 0..NUM_CLASSES-1
//  out_valid    out  1       result valid; held until out_ready
//  out_ready    in   1       downstream accepts result
//  out_index    out  IDX_W   winning class index
//  out_max      out  DATA_W  winning score (signed)
//  frame_cnt    out  16      completed frames delivered, wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=0 during reset then 1, out_valid=0, out_index=0, out_max=0,
//    frame_cnt=0, class counter=0. Reset mid-frame discards the partial frame.
//  - FSM: IDLE -> ACCUM on first accepted score (in_valid&in_ready); ACCUM -> DONE on
//    acceptance of score with counter==NUM_CLASSES-1; DONE -> IDLE on out_valid&out_ready.
//  - in_ready = 1 in IDLE/ACCUM, 0 in DONE (no overlap between frames).
//  - First score of frame loads max unconditionally (index 0). Later score k replaces max
//    only if strictly greater (signed compare): ties resolve to the LOWEST index.
//  - Latency: out_valid rises the cycle after the last score is accepted; out_index/out_max
//    stable while out_valid=1. Back-to-back: next frame's first score accepted the cycle
//    after the output handshake.
//  - frame_cnt increments on each output handshake.
//  - clear: highest priority after rst; in any state forces IDLE, out_valid=0, counter=0,
//    frame_cnt unchanged. clear coinciding with a handshake: handshake is void (no count).
//  - in_valid gaps mid-frame are legal; state and counter hold.
//  - Compare is full-width signed; no saturation, no truncation.
// CONFIGURATION
//  ARGMAX_TOP2_EN defined: adds ports out_index2 (IDX_W), out_max2 (DATA_W) and
//   out_margin (DATA_W+1, = out_max - out_max2, signed-extended, always >= 0). Second-best
//   tracked alongside best: new > best -> old best demoted to second; else new > second
//   (or second not yet loaded) -> replaces second. Ties keep lower index in both slots.
//   Reset/clear values 0. Same latency as out_index.
//  Not defined: ports absent, no second-best registers.
// STRUCTURE
//  Shared package cnn_pkg: DATA_W default (INTERNAL_BITS), state enum
//   {IDLE,ACCUM,DONE} typedef, score typedef signed [DATA_W-1:0].
//  One sub-module: argmax_cmp_slot (holds value+index, strict-greater update, load
//   strobe); instantiated once, twice with ARGMAX_TOP2_EN.
// TESTING
//  1. Scores 5,-3,17,2,9,0,-8,16,1,4 continuous valid -> out_valid 1 cycle after 10th,
//     out_index=2, out_max=17, frame_cnt=1.
//  2. All ten scores = -7 -> out_index=0 (lowest-index tie), out_max=-7.
//  3. Max at last slot (9th=0x7FFFFFFF), 0x80000000 elsewhere, random in_valid gaps ->
//     out_index=9; in_ready=0 while out_ready held low 5 cycles, result stable.
//  4. clear asserted after 4 scores, then full frame with max 3 at index 6 -> out_index=6;
//     no output from aborted frame; frame_cnt +1 only.
//  5. rst asserted mid-frame (after 7 scores) -> all outputs 0 next edge; fresh frame
//     then yields correct index.
//  6. ARGMAX_TOP2_EN, scores 1,8,3,8,7,... (rest <0) -> out_index=1, out_index2=3,
//     out_max2=8, out_margin=0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: internal score width, classifier FSM states and score type.
package cnn_pkg;

  localparam int unsigned INTERNAL_BITS = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic signed [INTERNAL_BITS-1:0] score_t;

endpackage

// File: rtl/argmax_cmp_slot.sv
// One argmax slot: holds a signed value and its class index, with a strict-greater comparator.
// The owner decides when to load; greater_c tells it whether the offered value beats the held one.
module argmax_cmp_slot
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = INTERNAL_BITS,
  parameter int unsigned IDX_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     load,
  input  logic signed [DATA_W-1:0] d_value,
  input  logic        [IDX_W-1:0]  d_index,
  output logic signed [DATA_W-1:0] value,
  output logic        [IDX_W-1:0]  index,
  output logic                     greater_c
);

  // Strict compare keeps the earlier (lower) index on ties.
  assign greater_c = d_value > value;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      index <= '0;
    end else if (clear) begin
      value <= '0;
      index <= '0;
    end else if (load) begin
      value <= d_value;
      index <= d_index;
    end
  end

endmodule

// File: rtl/argmax_stream_classifier.sv
// Streaming argmax over one frame of NUM_CLASSES signed class scores, valid/ready on both sides.
// Define ARGMAX_TOP2_EN to add second-best index/score and the best-minus-second margin.
module argmax_stream_classifier
  import cnn_pkg::*;
#(
  parameter  int unsigned DATA_W      = INTERNAL_BITS,
  parameter  int unsigned NUM_CLASSES = 10,
  localparam int unsigned IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [IDX_W-1:0]  out_index,
  output logic signed [DATA_W-1:0] out_max,
  output logic        [15:0]       frame_cnt
`ifdef ARGMAX_TOP2_EN
  ,
  output logic        [IDX_W-1:0]  out_index2,
  output logic signed [DATA_W-1:0] out_max2,
  output logic signed [DATA_W:0]   out_margin
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t             state, state_d;
  logic [IDX_W-1:0]   cnt, cnt_d;
  logic [15:0]        frame_cnt_d;
  logic               in_ready_d, out_valid_d;
  logic               accept, handshake;
  logic               load_first, cmp_en;
  logic               best_gt;
  logic signed [DATA_W-1:0] best_value;
  logic        [IDX_W-1:0]  best_index;

  assign accept    = in_valid & in_ready;
  assign handshake = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      frame_cnt <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      frame_cnt <= frame_cnt_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  // Next-state and slot strobes; clear overrides everything and voids a coincident handshake.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    frame_cnt_d = frame_cnt;
    load_first  = 1'b0;
    cmp_en      = 1'b0;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            load_first = 1'b1;
            cnt_d      = IDX_W'(1);
            state_d    = ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            cmp_en = 1'b1;
            if (cnt == LAST_IDX) begin
              cnt_d   = '0;
              state_d = DONE;
            end else begin
              cnt_d = cnt + IDX_W'(1);
            end
          end
        end
        DONE: begin
          if (handshake) begin
            frame_cnt_d = frame_cnt + 16'(1);
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    in_ready_d  = (state_d != DONE);
    out_valid_d = (state_d == DONE);
  end

  argmax_cmp_slot #(
    .DATA_W(DATA_W),
    .IDX_W (IDX_W)
  ) u_best (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .load     (load_first | (cmp_en & best_gt)),
    .d_value  (in_data),
    .d_index  (cnt),
    .value    (best_value),
    .index    (best_index),
    .greater_c(best_gt)
  );

  assign out_index = best_index;
  assign out_max   = best_value;

`ifdef ARGMAX_TOP2_EN
  logic signed [DATA_W-1:0] sec_value, sec_d_value;
  logic        [IDX_W-1:0]  sec_index, sec_d_index;
  logic                     sec_gt, sec_loaded, sec_load, demote;

  // A new best pushes the old best down; otherwise the newcomer may take second place.
  assign demote      = cmp_en & best_gt;
  assign sec_load    = cmp_en & (best_gt | sec_gt | ~sec_loaded);
  assign sec_d_value = demote ? best_value : in_data;
  assign sec_d_index = demote ? best_index : cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_loaded <= 1'b0;
    end else if (clear || load_first) begin
      sec_loaded <= 1'b0;
    end else if (sec_load) begin
      sec_loaded <= 1'b1;
    end
  end

  argmax_cmp_slot #(
    .DATA_W(DATA_W),
    .IDX_W (IDX_W)
  ) u_second (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .load     (sec_load),
    .d_value  (sec_d_value),
    .d_index  (sec_d_index),
    .value    (sec_value),
    .index    (sec_index),
    .greater_c(sec_gt)
  );

  assign out_index2 = sec_index;
  assign out_max2   = sec_value;
  assign out_margin = {best_value[DATA_W-1], best_value} - {sec_value[DATA_W-1], sec_value};
`endif

endmodule

// File: tb/tb_argmax_stream_classifier.sv
// Directed self-checking bench for argmax_stream_classifier (default 32-bit, 10-class build).
module tb_argmax_stream_classifier;

  logic               clk = 1'b0;
  logic               rst, clear, in_valid, in_ready, out_valid, out_ready;
  logic signed [31:0] in_data, out_max;
  logic        [3:0]  out_index;
  logic        [15:0] frame_cnt;
`ifdef ARGMAX_TOP2_EN
  logic        [3:0]  out_index2;
  logic signed [31:0] out_max2;
  logic signed [32:0] out_margin;
`endif

  int checks = 0;
  int errors = 0;
  logic signed [31:0] frame [10];

  always #5 clk = ~clk;

  argmax_stream_classifier dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_index(out_index),
    .out_max  (out_max),
    .frame_cnt(frame_cnt)
`ifdef ARGMAX_TOP2_EN
    ,
    .out_index2(out_index2),
    .out_max2  (out_max2),
    .out_margin(out_margin)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one score after 'gap' idle cycles and hold it until accepted (bounded).
  task automatic send_score(input logic signed [31:0] v, input int gap);
    in_valid = 1'b0;
    repeat (gap) step();
    in_data  = v;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        step();
        in_valid = 1'b0;
        return;
      end
      step();
    end
    checks++;
    errors++;
    $display("FAIL send_score_timeout: in_ready=%0d, required 1 within 20 cycles", in_ready);
    in_valid = 1'b0;
  endtask

  task automatic send_first(input int n, input int gap_max);
    for (int k = 0; k < n; k++) send_score(frame[k], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
  endtask

  task automatic do_handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (out_index !== 4'd0) begin errors++; $display("FAIL reset_out_index: got %0d expected 0", out_index); end
    checks++; if (out_max !== 32'sd0) begin errors++; $display("FAIL reset_out_max: got %0d expected 0", out_max); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
    rst = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %0b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    frame = '{32'sd5, -32'sd3, 32'sd17, 32'sd2, 32'sd9, 32'sd0, -32'sd8, 32'sd16, 32'sd1, 32'sd4};
    send_first(9, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %0b expected 0", out_valid); end
    send_score(frame[9], 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %0b expected 1", out_valid); end
    checks++; if (out_index !== 4'd2) begin errors++; $display("FAIL basic_index: got %0d expected 2", out_index); end
    checks++; if (out_max !== 32'sd17) begin errors++; $display("FAIL basic_max: got %0d expected 17", out_max); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_done: got %0b expected 0", in_ready); end
    do_handshake();
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL basic_frame_cnt: got %0d expected 1", frame_cnt); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %0b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready_idle: got %0b expected 1", in_ready); end
  endtask

  task automatic test_ties_back_to_back();
    for (int k = 0; k < 10; k++) frame[k] = -32'sd7;
    send_first(10, 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL tie_out_valid: got %0b expected 1", out_valid); end
    checks++; if (out_index !== 4'd0) begin errors++; $display("FAIL tie_index: got %0d expected 0", out_index); end
    checks++; if (out_max !== -32'sd7) begin errors++; $display("FAIL tie_max: got %0d expected -7", out_max); end
    do_handshake();
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL tie_frame_cnt: got %0d expected 2", frame_cnt); end
  endtask

  task automatic test_extremes_stall();
    for (int k = 0; k < 9; k++) frame[k] = 32'sh8000_0000;
    frame[9] = 32'sh7FFF_FFFF;
    send_first(10, 3);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ext_out_valid: got %0b expected 1", out_valid); end
    in_data  = 32'sd12345;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready c%0d: got %0b expected 0", c, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid c%0d: got %0b expected 1", c, out_valid); end
      checks++; if (out_index !== 4'd9) begin errors++; $display("FAIL stall_index c%0d: got %0d expected 9", c, out_index); end
      checks++; if (out_max !== 32'sh7FFF_FFFF) begin errors++; $display("FAIL stall_max c%0d: got %h expected 7fffffff", c, out_max); end
    end
    in_valid = 1'b0;
    do_handshake();
    checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL ext_frame_cnt: got %0d expected 3", frame_cnt); end
  endtask

  task automatic test_clear();
    frame = '{32'sd100, 32'sd200, 32'sd300, 32'sd400, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0};
    send_first(4, 0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_out_valid: got %0b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clear_in_ready: got %0b expected 1", in_ready); end
    frame = '{32'sd0, 32'sd1, 32'sd2, -32'sd5, 32'sd1, -32'sd2, 32'sd3, 32'sd2, 32'sd3, -32'sd9};
    send_first(9, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_early_valid: got %0b expected 0", out_valid); end
    send_score(frame[9], 0);
    checks++; if (out_index !== 4'd6) begin errors++; $display("FAIL clear_index: got %0d expected 6", out_index); end
    checks++; if (out_max !== 32'sd3) begin errors++; $display("FAIL clear_max: got %0d expected 3", out_max); end
    do_handshake();
    checks++; if (frame_cnt !== 16'd4) begin errors++; $display("FAIL clear_frame_cnt: got %0d expected 4", frame_cnt); end
  endtask

  task automatic test_clear_handshake();
    for (int k = 0; k < 10; k++) frame[k] = 32'(k + 1);
    send_first(10, 0);
    checks++; if (out_index !== 4'd9) begin errors++; $display("FAIL clrhs_index: got %0d expected 9", out_index); end
    out_ready = 1'b1;
    clear     = 1'b1;
    step();
    clear     = 1'b0;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clrhs_out_valid: got %0b expected 0", out_valid); end
    checks++; if (frame_cnt !== 16'd4) begin errors++; $display("FAIL clrhs_frame_cnt: got %0d expected 4", frame_cnt); end
  endtask

  task automatic test_reset_midframe();
    frame = '{32'sd1, 32'sd2, 32'sd30, 32'sd4, 32'sd5, 32'sd6, 32'sd7, 32'sd0, 32'sd0, 32'sd0};
    send_first(7, 0);
    rst = 1'b1;
    #1;
    checks++; if (out_max !== 32'sd0) begin errors++; $display("FAIL rstmid_max: got %0d expected 0", out_max); end
    checks++; if (out_index !== 4'd0) begin errors++; $display("FAIL rstmid_index: got %0d expected 0", out_index); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_frame_cnt: got %0d expected 0", frame_cnt); end
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready: got %0b expected 0", in_ready); end
    rst = 1'b0;
    step();
    frame = '{-32'sd4, -32'sd3, -32'sd2, -32'sd1, 32'sd50, 32'sd49, -32'sd50, 32'sd0, 32'sd50, 32'sd7};
    send_first(9, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_early_valid: got %0b expected 0", out_valid); end
    send_score(frame[9], 0);
    checks++; if (out_index !== 4'd4) begin errors++; $display("FAIL rstmid_fresh_index: got %0d expected 4", out_index); end
    checks++; if (out_max !== 32'sd50) begin errors++; $display("FAIL rstmid_fresh_max: got %0d expected 50", out_max); end
    do_handshake();
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL rstmid_frame_cnt_after: got %0d expected 1", frame_cnt); end
  endtask

`ifdef ARGMAX_TOP2_EN
  task automatic test_top2();
    frame = '{32'sd1, 32'sd8, 32'sd3, 32'sd8, 32'sd7, -32'sd1, -32'sd2, -32'sd3, -32'sd4, -32'sd5};
    send_first(10, 0);
    checks++; if (out_index !== 4'd1) begin errors++; $display("FAIL top2_index: got %0d expected 1", out_index); end
    checks++; if (out_index2 !== 4'd3) begin errors++; $display("FAIL top2_index2: got %0d expected 3", out_index2); end
    checks++; if (out_max2 !== 32'sd8) begin errors++; $display("FAIL top2_max2: got %0d expected 8", out_max2); end
    checks++; if (out_margin !== 33'sd0) begin errors++; $display("FAIL top2_margin: got %0d expected 0", out_margin); end
    do_handshake();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_ties_back_to_back();
    test_extremes_stall();
    test_clear();
    test_clear_handshake();
    test_reset_midframe();
`ifdef ARGMAX_TOP2_EN
    test_top2();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
